// File: rtl/control_unit_fsm.sv
// Multi-cycle processor control unit: sequences IF/ID/EXE/MEM/WB per opcode
// and decodes the datapath control strobes from state and the latched opcode.
// Optional jal/jr support is enabled by defining the CTRL_JAL_EN macro.
module control_unit_fsm #(
  parameter logic [5:0] HALT_OPCODE = 6'b111111,
  parameter logic [2:0] RESET_STATE = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       ext_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [2:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wr_data_src,
  output logic [2:0] state
);

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_J     = 6'b111000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;

`ifdef CTRL_JAL_EN
  localparam logic [5:0] OP_JR  = 6'b111001;
  localparam logic [5:0] OP_JAL = 6'b111010;
  localparam logic [1:0] PC_RS  = 2'd3;
  localparam logic [1:0] DST_RA = 2'd2;
  localparam logic [1:0] WD_PC4 = 2'd2;
`endif

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [5:0] op_q;
  logic [5:0] op_cur;

  // Immediates of arithmetic, compare, memory and branch ops are sign-extended
  function automatic logic sign_ext(input logic [5:0] op);
    case (op)
      OP_ADDIU, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  // Opcodes that proceed from ID into EXE
  function automatic logic goes_to_exe(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI,
      OP_SW, OP_LW, OP_BEQ, OP_BNE: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  assign state  = state_q;
  assign op_cur = (state_q == S_ID) ? opcode : op_q;

  // State register and opcode latch (opcode captured on the ID edge)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        op_q <= opcode;
      end
    end
  end

  // Next-state and control decode; all strobes forced low while in reset
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    pc_src      = PC_PLUS4;
    ir_write    = 1'b0;
    ext_sel     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    alu_op      = ALU_ADD;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = DST_RT;
    wr_data_src = WD_ALU;

    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        pc_src   = PC_PLUS4;
        state_d  = S_ID;
      end

      S_ID: begin
        ext_sel = sign_ext(op_cur);
        state_d = S_IF;
        if (op_cur == OP_J) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
`ifdef CTRL_JAL_EN
        else if (op_cur == OP_JAL) begin
          pc_write    = 1'b1;
          pc_src      = PC_JUMP;
          reg_write   = 1'b1;
          reg_dst     = DST_RA;
          wr_data_src = WD_PC4;
        end else if (op_cur == OP_JR) begin
          pc_write = 1'b1;
          pc_src   = PC_RS;
        end
`endif
        else if (op_cur == HALT_OPCODE) begin
          state_d = S_HALT;
        end else if (goes_to_exe(op_cur)) begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        ext_sel = sign_ext(op_cur);
        state_d = S_WB;
        case (op_cur)
          OP_BEQ, OP_BNE: begin
            alu_op   = ALU_SUB;
            pc_src   = PC_BRANCH;
            pc_write = (op_cur == OP_BEQ) ? zero : ~zero;
            state_d  = S_IF;
          end
          OP_LW, OP_SW: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_ADD:   alu_op = ALU_ADD;
          OP_SUB:   alu_op = ALU_SUB;
          OP_ADDIU: begin alu_op = ALU_ADD; alu_src_b = 1'b1; end
          OP_ANDI:  begin alu_op = ALU_AND; alu_src_b = 1'b1; end
          OP_ORI:   begin alu_op = ALU_OR;  alu_src_b = 1'b1; end
          OP_SLTI:  begin alu_op = ALU_SLT; alu_src_b = 1'b1; end
          default:  state_d = S_IF;
        endcase
      end

      S_MEM: begin
        ext_sel = sign_ext(op_cur);
        state_d = S_IF;
        if (op_cur == OP_LW) begin
          mem_read = 1'b1;
          state_d  = S_WB;
        end else if (op_cur == OP_SW) begin
          mem_write = 1'b1;
        end
      end

      S_WB: begin
        ext_sel     = sign_ext(op_cur);
        reg_write   = 1'b1;
        reg_dst     = (op_cur == OP_ADD || op_cur == OP_SUB) ? DST_RD : DST_RT;
        wr_data_src = (op_cur == OP_LW) ? WD_MEM : WD_ALU;
        state_d     = S_IF;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IF;
    endcase

    if (rst) begin
      pc_write    = 1'b0;
      pc_src      = PC_PLUS4;
      ir_write    = 1'b0;
      ext_sel     = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      alu_op      = ALU_ADD;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = DST_RT;
      wr_data_src = WD_ALU;
    end
  end

endmodule
